if_stage: RTL
=============

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter PC_INC, default 32'd4, giving the sequential PC increment.
REQ-003 The block SHALL have one clock, i_clk (input, 1 bit), with all state updating on its rising edge.
REQ-004 The block SHALL have i_reset (input, 1 bit), a synchronous, active-low reset.
REQ-005 The block SHALL have i_pc_sel (input, 1 bit): 1 means take the redirect target; driven by the decoder's pc_sel.
REQ-006 The block SHALL have i_alu_data (input, 32 bits): the branch/redirect target address.
REQ-007 The block SHALL have i_stall (input, 1 bit): 1 means hold the current instruction.
REQ-008 The block SHALL have o_imem_req (output, 1 bit): instruction memory request strobe.
REQ-009 The block SHALL have o_imem_addr (output, 32 bits): word-aligned fetch address.
REQ-010 The block SHALL have i_imem_rvalid (input, 1 bit): read data valid.
REQ-011 The block SHALL have i_imem_rdata (input, 32 bits): read data.
REQ-012 The block SHALL have o_inst (output, 32 bits): instruction presented to the decoder.
REQ-013 The block SHALL have o_pc (output, 32 bits): address of o_inst.
REQ-014 The block SHALL have o_pc_four (output, 32 bits): o_pc + PC_INC, used for link writeback.
REQ-015 The block SHALL have o_inst_vld (output, 1 bit): 1 means o_inst/o_pc are valid.
REQ-016 The block SHALL have o_inst_cnt (output, 32 bits): count of instructions consumed.

Function
REQ-017 The block SHALL have FSM states IDLE, FETCH, WAIT, VALID.
REQ-018 IDLE SHALL last one cycle and then go to FETCH; all outputs are inactive in IDLE.
REQ-019 In FETCH, o_imem_req SHALL be 1 for exactly one cycle with o_imem_addr = pc, and the FSM SHALL go to WAIT on the next cycle.
REQ-020 o_imem_req SHALL be 0 in every state other than FETCH, and at most one request SHALL be outstanding.
REQ-021 In WAIT, when i_imem_rvalid=1, the block SHALL capture i_imem_rdata into o_inst and go to VALID; otherwise it SHALL remain in WAIT indefinitely.
REQ-022 i_imem_rvalid outside WAIT SHALL be ignored, with no state or output change.
REQ-023 In VALID, o_inst_vld SHALL be 1, and o_inst, o_pc and o_pc_four SHALL be stable.
REQ-024 In VALID with i_stall=1, the block SHALL hold all outputs and state, and i_pc_sel SHALL be ignored.
REQ-025 In VALID with i_stall=0 (consume), the next pc SHALL be {i_alu_data[31:2],2'b00} if i_pc_sel=1, else pc+PC_INC; the FSM SHALL go to FETCH and o_inst_cnt SHALL increment by 1.
REQ-026 i_pc_sel SHALL be sampled only on a consume cycle.
REQ-027 Redirect target bits [1:0] SHALL be forced to zero, with no fault raised.
REQ-028 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 o_inst_cnt SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 o_pc_four SHALL equal o_pc + PC_INC, combinationally, in all states.
REQ-031 o_imem_addr SHALL equal pc in all states; it is only meaningful while o_imem_req=1.
REQ-032 o_inst_vld SHALL be 0 in IDLE, FETCH and WAIT.
REQ-033 Minimum latency from consume to the next o_inst_vld SHALL be 3 cycles when rvalid arrives 1 cycle after req (FETCH, WAIT, VALID).
REQ-034 Simultaneous i_reset=0 and i_imem_rvalid=1 SHALL be resolved in favour of reset: data is discarded.

Reset
REQ-035 While i_reset=0 at a rising edge, the block SHALL set state=IDLE, pc=RESET_PC, o_inst=32'h0000_0013 (NOP), o_inst_vld=0, o_imem_req=0 and o_inst_cnt=0.
REQ-036 A reset asserted in any state, including mid-WAIT, SHALL abort the operation, and the first request after reset SHALL use RESET_PC.
REQ-037 Reset SHALL take effect on the clock edge only; the block SHALL have no asynchronous paths.

Verification
REQ-038 The bench SHALL cover reset release with rvalid 1 cycle after req and rdata=32'h00500093 -> req at addr 0 on cycle 2, o_inst_vld=1 on cycle 4 with o_inst=32'h00500093, o_pc=0, o_pc_four=4.
REQ-039 The bench SHALL cover a consume with i_pc_sel=0 at pc=0x10 -> next req addr 0x14 and o_inst_cnt incremented by 1.
REQ-040 The bench SHALL cover a consume with i_pc_sel=1 and i_alu_data=0x0000_0103 -> next req addr 0x0000_0100.
REQ-041 The bench SHALL cover i_stall=1 for 5 cycles in VALID while i_pc_sel toggles -> o_inst, o_pc and o_inst_cnt unchanged and no req issued.
REQ-042 The bench SHALL cover rvalid delayed 7 cycles, plus a stray rvalid in VALID -> o_imem_req high for 1 cycle only and stray data ignored.
REQ-043 The bench SHALL cover i_reset=0 asserted in WAIT with rvalid on the same edge -> o_inst=NOP, o_inst_vld=0, then req at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time,
// captures the returned word and holds it for the decoder until consumed.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pc_sel,
  input  logic [31:0] i_alu_data,
  input  logic        i_stall,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_four,
  output logic        o_inst_vld,
  output logic [31:0] o_inst_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    VALID = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        consume;

  assign consume = (state_q == VALID) && !i_stall;

  // Reset wins over any same-edge read data, so an in-flight fetch is dropped.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: state_d = WAIT;
      WAIT: begin
        if (i_imem_rvalid) begin
          inst_d  = i_imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        // Redirect targets are silently word-aligned; no misalignment fault exists here.
        if (consume) begin
          pc_d    = i_pc_sel ? (i_alu_data & 32'hFFFF_FFFC) : (pc_q + PC_INC);
          cnt_d   = cnt_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_imem_req  = (state_q == FETCH);
  assign o_imem_addr = pc_q;
  assign o_inst      = inst_q;
  assign o_pc        = pc_q;
  assign o_pc_four   = pc_q + PC_INC;
  assign o_inst_vld  = (state_q == VALID);
  assign o_inst_cnt  = cnt_q;

endmodule
